// File: rtl/pixel_fb_pkg.sv
// Shared types and defaults for the ping-pong pixel frame buffer.
// Holds the fill-engine state encoding and the power-up pixel value.
package pixel_fb_pkg;

  localparam logic [15:0] FB_INIT_VALUE = 16'h8000;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } fill_state_t;

endpackage

// File: rtl/pixel_ram_bank.sv
// One DATA_W x 2**ADDR_W pixel bank: bit-masked write port, registered read port.
// Contents power up to INIT_VALUE and are never touched by reset.
module pixel_ram_bank #(
  parameter int              DATA_W     = 16,
  parameter int              ADDR_W     = 8,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [DATA_W-1:0] w_mask,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DATA_W-1:0] r_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_VALUE};

  // A set mask bit preserves the stored bit; a clear bit takes the new data.
  always_ff @(posedge clk) begin
    if (w_en) begin
      mem[w_addr] <= (mem[w_addr] & w_mask) | (w_data & ~w_mask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (r_en) begin
      r_data <= mem[r_addr];
    end
  end

endmodule

// File: rtl/pixel_frame_buffer.sv
// Double-buffered pixel store: writer fills the back bank, scan-out reads the front bank.
// Bank swaps are requested and deferred to a frame end; a fill engine clears the back bank.
module pixel_frame_buffer
  import pixel_fb_pkg::*;
#(
  parameter int                DATA_W            = 16,
  parameter int                ADDR_W            = 8,
  parameter logic [DATA_W-1:0] INIT_VALUE        = DATA_W'(FB_INIT_VALUE),
  parameter bit                SWAP_ON_FRAME_END = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_w_addr,
  input  logic [DATA_W-1:0] i_w_data,
  input  logic [DATA_W-1:0] i_w_mask,
  input  logic              i_w_enable,
  output logic              o_w_ready,
  input  logic [ADDR_W-1:0] i_r_addr,
  input  logic              i_r_enable,
  output logic [DATA_W-1:0] o_r_data,
  output logic              o_r_valid,
  input  logic              i_swap_req,
  input  logic              i_frame_end,
  output logic              o_swap_pending,
  output logic              o_swap_done,
  output logic              o_front_sel,
  input  logic              i_fill_start,
  input  logic [DATA_W-1:0] i_fill_value,
  output logic              o_fill_busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  fill_state_t       state;
  fill_state_t       state_next;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_value;
  logic              fill_busy;
  logic              fill_we;

  logic              front_sel;
  logic              swap_pending;
  logic              swap_done;
  logic              swap_go;
  logic              rd_sel;
  logic              r_valid;

  logic              back_w_en;
  logic [ADDR_W-1:0] back_w_addr;
  logic [DATA_W-1:0] back_w_data;
  logic [DATA_W-1:0] back_w_mask;
  logic [DATA_W-1:0] bank_r_data [2];

  // Fill FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (i_fill_start) state_next = S_FILL;
      S_FILL: if (fill_addr == LAST_ADDR) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    fill_busy = 1'b0;
    fill_we   = 1'b0;
    if (state == S_FILL) begin
      fill_busy = 1'b1;
      fill_we   = 1'b1;
    end
  end

  // Fill word and address are captured only when a fill is accepted from idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fill_addr  <= '0;
      fill_value <= '0;
    end else if (state == S_IDLE && i_fill_start) begin
      fill_addr  <= '0;
      fill_value <= i_fill_value;
    end else if (fill_we) begin
      fill_addr <= fill_addr + ADDR_W'(1);
    end
  end

  assign swap_go = swap_pending && !fill_busy && (i_frame_end || !SWAP_ON_FRAME_END);

  // A request arriving on the execution cycle re-arms, so back-to-back pulses give two swaps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      front_sel    <= 1'b0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
    end else begin
      front_sel    <= front_sel ^ swap_go;
      swap_pending <= (swap_pending && !swap_go) || i_swap_req;
      swap_done    <= swap_go;
    end
  end

  always_comb begin
    back_w_en   = fill_we || (i_w_enable && !fill_busy);
    back_w_addr = i_w_addr;
    back_w_data = i_w_data;
    back_w_mask = i_w_mask;
    if (fill_we) begin
      back_w_addr = fill_addr;
      back_w_data = fill_value;
      back_w_mask = '0;
    end
  end

  // rd_sel remembers which bank served the last strobe so a later swap cannot change held data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_sel  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_r_enable;
      if (i_r_enable) begin
        rd_sel <= front_sel;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic IDX = 1'(b);

    pixel_ram_bank #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .INIT_VALUE (INIT_VALUE)
    ) u_bank (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .w_en   (back_w_en && (front_sel != IDX)),
      .w_addr (back_w_addr),
      .w_data (back_w_data),
      .w_mask (back_w_mask),
      .r_en   (i_r_enable && (front_sel == IDX)),
      .r_addr (i_r_addr),
      .r_data (bank_r_data[b])
    );
  end

  assign o_r_data       = rd_sel ? bank_r_data[1] : bank_r_data[0];
  assign o_r_valid      = r_valid;
  assign o_w_ready      = !fill_busy;
  assign o_fill_busy    = fill_busy;
  assign o_front_sel    = front_sel;
  assign o_swap_pending = swap_pending;
  assign o_swap_done    = swap_done;

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Directed bench for pixel_frame_buffer: frame-end swap instance plus an immediate-swap instance.
// Expected values are hand-computed from the bank/swap/fill behaviour.
module tb_pixel_frame_buffer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  w_addr;
  logic [15:0] w_data;
  logic [15:0] w_mask;
  logic        w_enable;
  logic        w_ready;
  logic [7:0]  r_addr;
  logic        r_enable;
  logic [15:0] r_data;
  logic        r_valid;
  logic        swap_req;
  logic        frame_end;
  logic        swap_pending;
  logic        swap_done;
  logic        front_sel;
  logic        fill_start;
  logic [15:0] fill_value;
  logic        fill_busy;

  logic        b_swap_req;
  logic        b_w_ready;
  logic [15:0] b_r_data;
  logic        b_r_valid;
  logic        b_swap_pending;
  logic        b_swap_done;
  logic        b_front_sel;
  logic        b_fill_busy;

  int checks_done;
  int checks_failed;
  int cnt;

  pixel_frame_buffer #(
    .DATA_W (16), .ADDR_W (8), .INIT_VALUE (16'h8000), .SWAP_ON_FRAME_END (1'b1)
  ) u_dut (
    .i_clk (clk), .i_rst_n (rst_n),
    .i_w_addr (w_addr), .i_w_data (w_data), .i_w_mask (w_mask),
    .i_w_enable (w_enable), .o_w_ready (w_ready),
    .i_r_addr (r_addr), .i_r_enable (r_enable),
    .o_r_data (r_data), .o_r_valid (r_valid),
    .i_swap_req (swap_req), .i_frame_end (frame_end),
    .o_swap_pending (swap_pending), .o_swap_done (swap_done), .o_front_sel (front_sel),
    .i_fill_start (fill_start), .i_fill_value (fill_value), .o_fill_busy (fill_busy)
  );

  pixel_frame_buffer #(
    .DATA_W (16), .ADDR_W (8), .INIT_VALUE (16'h8000), .SWAP_ON_FRAME_END (1'b0)
  ) u_dut_imm (
    .i_clk (clk), .i_rst_n (rst_n),
    .i_w_addr (8'h00), .i_w_data (16'h0000), .i_w_mask (16'h0000),
    .i_w_enable (1'b0), .o_w_ready (b_w_ready),
    .i_r_addr (8'h00), .i_r_enable (1'b0),
    .o_r_data (b_r_data), .o_r_valid (b_r_valid),
    .i_swap_req (b_swap_req), .i_frame_end (1'b0),
    .o_swap_pending (b_swap_pending), .o_swap_done (b_swap_done), .o_front_sel (b_front_sel),
    .i_fill_start (1'b0), .i_fill_value (16'h0000), .o_fill_busy (b_fill_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks_done++;
    assert (observed === expected)
    else begin
      checks_failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] addr, input logic [15:0] data, input logic [15:0] mask);
    w_addr   = addr;
    w_data   = data;
    w_mask   = mask;
    w_enable = 1'b1;
    tick();
    w_enable = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [7:0] addr, input logic [15:0] expected);
    r_addr   = addr;
    r_enable = 1'b1;
    tick();
    r_enable = 1'b0;
    check_output({tag, "_valid"}, 32'(r_valid), 32'd1);
    check_output({tag, "_data"}, 32'(r_data), 32'(expected));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_r_data"}, 32'(r_data), 32'h0);
    check_output({tag, "_r_valid"}, 32'(r_valid), 32'd0);
    check_output({tag, "_front_sel"}, 32'(front_sel), 32'd0);
    check_output({tag, "_swap_pending"}, 32'(swap_pending), 32'd0);
    check_output({tag, "_swap_done"}, 32'(swap_done), 32'd0);
    check_output({tag, "_fill_busy"}, 32'(fill_busy), 32'd0);
    check_output({tag, "_w_ready"}, 32'(w_ready), 32'd1);
  endtask

  initial begin
    checks_done   = 0;
    checks_failed = 0;
    rst_n      = 1'b0;
    w_addr     = '0;
    w_data     = '0;
    w_mask     = '0;
    w_enable   = 1'b0;
    r_addr     = '0;
    r_enable   = 1'b0;
    swap_req   = 1'b0;
    frame_end  = 1'b0;
    fill_start = 1'b0;
    fill_value = '0;
    b_swap_req = 1'b0;

    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Power-up content is INIT_VALUE in the front bank.
    read_check("pwr_rd_00", 8'h00, 16'h8000);
    read_check("pwr_rd_ff", 8'hFF, 16'h8000);
    tick();
    check_output("idle_valid_low", 32'(r_valid), 32'd0);
    check_output("idle_data_hold", 32'(r_data), 32'h8000);
    check_output("pwr_front_sel", 32'(front_sel), 32'd0);

    // Write to back bank leaves front untouched.
    apply_stimulus(8'h10, 16'h1234, 16'h0000);
    read_check("front_untouched", 8'h10, 16'h8000);

    // Frame end with nothing pending does nothing.
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check_output("lone_fe_done", 32'(swap_done), 32'd0);
    check_output("lone_fe_front", 32'(front_sel), 32'd0);

    // Request and frame end together: request latches, swap waits for next frame end.
    swap_req  = 1'b1;
    frame_end = 1'b1;
    tick();
    swap_req  = 1'b0;
    frame_end = 1'b0;
    check_output("same_cyc_pending", 32'(swap_pending), 32'd1);
    check_output("same_cyc_done", 32'(swap_done), 32'd0);
    check_output("same_cyc_front", 32'(front_sel), 32'd0);
    tick();
    check_output("wait_fe_front", 32'(front_sel), 32'd0);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check_output("swap1_done", 32'(swap_done), 32'd1);
    check_output("swap1_front", 32'(front_sel), 32'd1);
    check_output("swap1_pending", 32'(swap_pending), 32'd0);
    tick();
    check_output("swap1_done_pulse", 32'(swap_done), 32'd0);
    read_check("swap1_rd_10", 8'h10, 16'h1234);

    // Masked write into back bank 0: FFFF then 0000 with mask FF00 gives FF00.
    apply_stimulus(8'h20, 16'hFFFF, 16'h0000);
    apply_stimulus(8'h20, 16'h0000, 16'hFF00);
    swap_req = 1'b1;
    tick();
    swap_req  = 1'b0;
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check_output("swap2_front", 32'(front_sel), 32'd0);
    read_check("mask_rd_20", 8'h20, 16'hFF00);
    read_check("mask_rd_10", 8'h10, 16'h8000);

    // Fill back bank 1 with 0F0F; a user write in the start cycle is accepted.
    fill_start = 1'b1;
    fill_value = 16'h0F0F;
    apply_stimulus(8'h30, 16'hABCD, 16'h0000);
    fill_start = 1'b0;
    fill_value = 16'h0000;
    check_output("fill_busy_start", 32'(fill_busy), 32'd1);
    check_output("fill_w_ready", 32'(w_ready), 32'd0);
    cnt = 0;
    while (fill_busy === 1'b1 && cnt < 400) begin
      cnt++;
      w_enable  = (cnt == 250);
      w_addr    = 8'h05;
      w_data    = 16'h5555;
      w_mask    = 16'h0000;
      swap_req  = (cnt == 20 || cnt == 21);
      frame_end = (cnt == 30 || cnt == 256);
      tick();
      if (cnt == 30) begin
        check_output("midfill_front", 32'(front_sel), 32'd0);
        check_output("midfill_pending", 32'(swap_pending), 32'd1);
        check_output("midfill_done", 32'(swap_done), 32'd0);
      end
    end
    w_enable  = 1'b0;
    swap_req  = 1'b0;
    frame_end = 1'b0;
    check_output("fill_busy_cycles", 32'(cnt), 32'd256);
    check_output("lastfill_fe_front", 32'(front_sel), 32'd0);
    check_output("postfill_pending", 32'(swap_pending), 32'd1);
    check_output("postfill_w_ready", 32'(w_ready), 32'd1);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check_output("fill_swap_done", 32'(swap_done), 32'd1);
    check_output("fill_swap_front", 32'(front_sel), 32'd1);
    for (int i = 0; i < 256; i++) begin
      read_check($sformatf("fill_rd_%0d", i), 8'(i), 16'h0F0F);
    end

    // Reset at fill cycle 100 with a swap pending: fill aborts, bank 0 partially filled.
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check_output("rst_pre_pending", 32'(swap_pending), 32'd1);
    fill_start = 1'b1;
    fill_value = 16'h3C3C;
    tick();
    fill_start = 1'b0;
    repeat (100) tick();
    check_output("rst_pre_busy", 32'(fill_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 256; i++) begin
      read_check($sformatf("abort_rd_%0d", i), 8'(i), (i < 100) ? 16'h3C3C : 16'h8000);
    end

    // Immediate-swap instance: swap on the cycle after the request, back-to-back gives two swaps.
    check_output("imm_reset_front", 32'(b_front_sel), 32'd0);
    b_swap_req = 1'b1;
    tick();
    b_swap_req = 1'b0;
    check_output("imm_pending", 32'(b_swap_pending), 32'd1);
    check_output("imm_done_early", 32'(b_swap_done), 32'd0);
    tick();
    check_output("imm_done", 32'(b_swap_done), 32'd1);
    check_output("imm_front", 32'(b_front_sel), 32'd1);
    check_output("imm_pending_clr", 32'(b_swap_pending), 32'd0);
    b_swap_req = 1'b1;
    tick();
    tick();
    b_swap_req = 1'b0;
    check_output("b2b_first_done", 32'(b_swap_done), 32'd1);
    check_output("b2b_first_front", 32'(b_front_sel), 32'd0);
    tick();
    check_output("b2b_second_done", 32'(b_swap_done), 32'd1);
    check_output("b2b_second_front", 32'(b_front_sel), 32'd1);
    tick();
    check_output("b2b_quiet_done", 32'(b_swap_done), 32'd0);
    check_output("b2b_quiet_pending", 32'(b_swap_pending), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks_done, checks_failed);
    $finish;
  end

endmodule
